// File: rtl/img_scan.sv
`default_nettype none
// ============================================================================
// Module      : img_scan
// Description : Raster-order frame scanner: reads IMG_W x IMG_H bytes from the
//               image RAM and emits them as a marked valid/ready pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module img_scan #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_addr;

    logic w_fetch;
    logic w_x_last;
    logic w_y_last;

    // Output slot is free when empty or being accepted this cycle.
    assign w_fetch  = !pix_valid || pix_ready;
    assign w_x_last = (r_x == C_X_LAST);
    assign w_y_last = (r_y == C_Y_LAST);

    assign busy     = (r_state != ST_IDLE);
    assign ram_read = (r_state == ST_SCAN) && w_fetch;
    assign ram_addr = r_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                r_state   <= ST_IDLE;
                pix_valid <= 1'b0;
                pix_sof   <= 1'b0;
                pix_eol   <= 1'b0;
                pix_eof   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_SCAN;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_addr  <= '0;
                        end
                    end
                    ST_SCAN: begin
                        if (w_fetch) begin
                            pix_data  <= ram_data;
                            pix_valid <= 1'b1;
                            pix_sof   <= (r_x == '0) && (r_y == '0);
                            pix_eol   <= w_x_last;
                            pix_eof   <= w_x_last && w_y_last;
                            // Counters freeze on the last pixel so addr stays in range.
                            if (w_x_last && w_y_last) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_addr <= r_addr + ADDR_W'(1);
                                if (w_x_last) begin
                                    r_x <= '0;
                                    r_y <= r_y + YW'(1);
                                end else begin
                                    r_x <= r_x + XW'(1);
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (pix_valid && pix_ready) begin
                            pix_valid <= 1'b0;
                            pix_sof   <= 1'b0;
                            pix_eol   <= 1'b0;
                            pix_eof   <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/img_scan.md
# img_scan

Frame scanner for the play_gif image path. It reads a stored IMG_W x IMG_H 8-bit image out of the byte read port of the image RAM, one byte per cycle in raster order. It emits the bytes as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers, and it is the consumer-side counterpart of the line-packed writer that fills the RAM.

## Interface
- IMG_W, 32, pixels per line (>= 2)
- IMG_H, 32, lines per frame (>= 1)
- ADDR_W, 10, RAM byte-address width; IMG_W*IMG_H <= 2**ADDR_W
- clk  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame scan; sampled only in IDLE
- abort  in  1  synchronous cancel of the current scan
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last pixel is accepted downstream
- ram_read  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM byte address
- ram_data  in  8  RAM read data, combinational from ram_addr/ram_read, 0 when ram_read low
- pix_data  out  8  pixel byte
- pix_valid  out  1  pixel beat valid
- pix_ready  in  1  downstream accept
- pix_sof  out  1  beat is pixel (0,0)
- pix_eol  out  1  beat is the last pixel of a line (x == IMG_W-1)
- pix_eof  out  1  beat is the last pixel of the frame

## Operation
- Registers: state {IDLE, SCAN, DRAIN}; x (0..IMG_W-1); y (0..IMG_H-1); linear addr counter; output register pix_data/pix_valid/pix_sof/pix_eol/pix_eof.
- ram_addr = addr counter, always driven. ram_read = (state == SCAN) && fetch, where fetch = !pix_valid || pix_ready.
- IDLE, start=1, abort=0: move to SCAN; x, y and addr are cleared to 0.
- SCAN on a fetch edge:
  - pix_data <= ram_data and pix_valid <= 1.
  - pix_sof <= (x==0 && y==0); pix_eol <= (x==IMG_W-1); pix_eof <= (x==IMG_W-1 && y==IMG_H-1).
  - x, y and addr advance. x wraps to 0 and y increments at the end of each line.
  - If this is the last pixel, go to DRAIN and stop advancing the counters.
- SCAN without fetch (pix_valid && !pix_ready): everything holds and ram_read stays 0.
- DRAIN: when pix_valid && pix_ready, pix_valid and all markers go to 0, done pulses, and state goes to IDLE.
- A beat never changes while pix_valid && !pix_ready. Pixels are never dropped or duplicated.
- start while busy is ignored.
- abort=1 in any state, on the next edge:
  - state goes to IDLE, and pix_valid and all markers go to 0;
  - no done pulse is produced.
  - abort wins over a simultaneous start.
- Counters are sized to $clog2 of their range. addr never exceeds IMG_W*IMG_H-1.

## Timing
- Reset values, applied asynchronously when reset_n=0:
  - state=IDLE, x=y=addr=0;
  - pix_data=0, pix_valid=0, pix_sof=0, pix_eol=0, pix_eof=0;
  - done=0, busy=0, ram_read=0, ram_addr=0.
- A reset mid-frame discards the frame. Scanning resumes only after a new start.
- Edge E0 samples start. busy rises after E0, and ram_read is high from E0 until the last fetch whenever fetch holds.
- With pix_ready held high:
  - pixel k appears after edge E(k+1) with pix_data = RAM byte k;
  - the last pixel appears after E(IMG_W*IMG_H);
  - done is high and busy low after E(IMG_W*IMG_H+1).
- Throughput is 1 pixel/cycle. Read-data latency is one cycle, from ram_read to pix_data.
- The path pix_ready -> ram_read -> ram_data -> pix_data register is combinational within one cycle.
- The next start is accepted in the cycle done is high.

## Test plan
- RAM byte k = k[7:0], pix_ready=1, pulse start:
  - 1024 beats with pix_data = k mod 256;
  - pix_sof only on k=0, pix_eol on k%32==31, pix_eof only on k=1023;
  - done exactly 1025 cycles after the start edge.
- Random pix_ready (≈50%):
  - the sequence is identical to the previous test;
  - pix_data and markers stay stable while stalled, and ram_read=0 on stalled cycles.
- abort asserted while beat 500 is valid: pix_valid=0 on the next edge, busy=0, no done; a new start yields pix_data=0 with pix_sof.
- start pulsed while busy at beat 200: ignored; the frame completes normally with a single done.
- reset_n driven low asynchronously mid-frame (between edges): all outputs 0 immediately. After release, no beats until start.
- IMG_W=4, IMG_H=2, pix_ready=1: 8 beats, pix_eol on beats 3 and 7, pix_eof on beat 7, done after edge E9.
